// File: rtl/result_compactor.sv
// Result compactor: folds kernel output stream words down to OUT_W bits and
// either forwards every folded beat (MODE 0) or emits one signature per run (MODE 1).
module result_compactor #(
  parameter int NUM_CH = 1,
  parameter int DATA_W = 32,
  parameter int OUT_W  = 4,
  parameter int MODE   = 0,
  parameter int CNT_W  = 16
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst_n,
  input  logic                     ap_start,
  input  logic                     ap_done,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_write,
  output logic [OUT_W-1:0]         data_out,
  output logic                     data_valid,
  output logic [CNT_W-1:0]         beat_cnt,
  output logic                     overflow
);

  localparam int SLICES = DATA_W / OUT_W;
  localparam bit SIG_MODE = (MODE != 0);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, EMIT} state_t;

  function automatic logic [OUT_W-1:0] fold_word(input logic [DATA_W-1:0] w);
    logic [OUT_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < SLICES; i++) begin
      acc = acc ^ w[i*OUT_W +: OUT_W];
    end
    return acc;
  endfunction

  function automatic logic [OUT_W-1:0] rotl1(input logic [OUT_W-1:0] s);
    return {s[OUT_W-2:0], s[OUT_W-1]};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  state_t             state_q, state_d;
  logic               start_q;
  logic               start_rise;
  logic               run_start;
  logic               gate;
  logic [NUM_CH-1:0]  wr_p0;
  logic [OUT_W-1:0]   fold_p0;
  logic               vld_p0;
  logic [OUT_W-1:0]   fold_p1;
  logic               vld_p1;
  logic [OUT_W-1:0]   sig;

  assign start_rise = ap_start & ~start_q;
  // In signature mode a start edge only counts while the FSM is waiting for one.
  assign run_start  = SIG_MODE ? (start_rise && state_q == IDLE) : start_rise;
  assign gate       = SIG_MODE ? (state_q == RUN) : 1'b1;

  always_comb begin
    wr_p0   = in_write & {NUM_CH{gate}};
    fold_p0 = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (wr_p0[c]) fold_p0 = fold_p0 ^ fold_word(in_data[c*DATA_W +: DATA_W]);
    end
    vld_p0 = |wr_p0;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_rise) state_d = RUN;
      RUN:     if (ap_done)    state_d = DRAIN;
      DRAIN:   state_d = EMIT;
      EMIT:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= IDLE;
      start_q <= 1'b0;
    end else begin
      state_q <= SIG_MODE ? state_d : IDLE;
      start_q <= ap_start;
    end
  end

  // ---- stage p0 -> p1: folded beat ----
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      fold_p1 <= '0;
      vld_p1  <= 1'b0;
    end else begin
      fold_p1 <= fold_p0;
      vld_p1  <= vld_p0;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      beat_cnt <= '0;
      overflow <= 1'b0;
    end else if (run_start) begin
      beat_cnt <= '0;
      overflow <= 1'b0;
    end else if (vld_p1) begin
      beat_cnt <= sat_inc(beat_cnt);
      if (&beat_cnt) overflow <= 1'b1;
    end
  end

  // The DRAIN cycle absorbs a beat written together with ap_done.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      sig <= '0;
    end else if (run_start) begin
      sig <= '0;
    end else if (vld_p1 && (state_q == RUN || state_q == DRAIN)) begin
      sig <= rotl1(sig) ^ fold_p1;
    end
  end

  // ---- stage p1 -> p2: output register ----
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      data_out   <= '0;
      data_valid <= 1'b0;
    end else if (SIG_MODE) begin
      data_out   <= (state_q == EMIT) ? sig : '0;
      data_valid <= (state_q == EMIT);
    end else begin
      data_out   <= fold_p1;
      data_valid <= vld_p1;
    end
  end

endmodule

// File: tb/tb_result_compactor.sv
// Scoreboard bench for result_compactor: u0 in per-beat mode (2 channels),
// u1 in signature mode with a 4-bit beat counter.
module tb_result_compactor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start0, done0;
  logic [63:0] din0;
  logic [1:0]  wr0;
  logic [3:0]  out0;
  logic        vld0;
  logic [15:0] cnt0;
  logic        ovf0;

  logic        start1, done1;
  logic [31:0] din1;
  logic [0:0]  wr1;
  logic [3:0]  out1;
  logic        vld1;
  logic [3:0]  cnt1;
  logic        ovf1;

  result_compactor #(.NUM_CH(2), .DATA_W(32), .OUT_W(4), .MODE(0), .CNT_W(16)) u0 (
    .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(start0), .ap_done(done0),
    .in_data(din0), .in_write(wr0), .data_out(out0), .data_valid(vld0),
    .beat_cnt(cnt0), .overflow(ovf0)
  );

  result_compactor #(.NUM_CH(1), .DATA_W(32), .OUT_W(4), .MODE(1), .CNT_W(4)) u1 (
    .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(start1), .ap_done(done1),
    .in_data(din1), .in_write(wr1), .data_out(out1), .data_valid(vld1),
    .beat_cnt(cnt1), .overflow(ovf1)
  );

  typedef struct {
    logic [3:0]  d;
    logic [15:0] c;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int vld1_cyc = -1;
  int done_cyc = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (vld0) begin
      if (q0.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL u0_spurious_valid: got data 0x%0h, expected no output", out0);
      end else begin
        e0 = q0.pop_front();
        check("u0_data", 32'(out0), 32'(e0.d));
        check("u0_beat_cnt", 32'(cnt0), 32'(e0.c));
      end
    end
  end

  always @(negedge clk) begin
    if (vld1) begin
      vld1_cyc = cyc;
      if (q1.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL u1_spurious_valid: got data 0x%0h, expected no output", out1);
      end else begin
        e1 = q1.pop_front();
        check("u1_signature", 32'(out1), 32'(e1.d));
        check("u1_beat_cnt", 32'(cnt1), 32'(e1.c));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Two beats (fold 1 then 4, done with the second) plus an excluded beat after done.
  task automatic run_two_beats();
    q1.push_back('{d: 4'h6, c: 16'd2});
    start1 = 1'b1;
    tick();
    start1 = 1'b0; din1 = 32'h0000_0001; wr1 = 1'b1;
    tick();
    din1 = 32'h0000_0004; done1 = 1'b1; done_cyc = cyc;
    tick();
    din1 = 32'h0000_000F; done1 = 1'b0;
    tick();
    wr1 = 1'b0; din1 = '0;
    repeat (6) tick();
    check("u1_emit_latency", 32'(vld1_cyc - done_cyc), 32'd3);
    check("u1_cnt_after_run", 32'(cnt1), 32'd2);
  endtask

  initial begin
    rst_n = 1'b0;
    start0 = 1'b0; done0 = 1'b0; din0 = '0; wr0 = '0;
    start1 = 1'b0; done1 = 1'b0; din1 = '0; wr1 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_u0_data", 32'(out0), 0);
    check("rst_u0_valid", 32'(vld0), 0);
    check("rst_u0_cnt", 32'(cnt0), 0);
    check("rst_u1_data", 32'(out1), 0);
    check("rst_u1_valid", 32'(vld1), 0);
    check("rst_u1_cnt", 32'(cnt1), 0);
    check("rst_u1_ovf", 32'(ovf1), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // per-beat mode: 1^2^..^8 = 8; 0xF ^ 0xF0 folds cancel; 0xA5 -> F; 0x3 -> 3
    din0 = {32'h0, 32'h1234_5678}; wr0 = 2'b01; q0.push_back('{d: 4'h8, c: 16'd1});
    tick();
    din0 = {32'h0000_00F0, 32'h0000_000F}; wr0 = 2'b11; q0.push_back('{d: 4'h0, c: 16'd2});
    tick();
    din0 = {32'h0000_00A5, 32'hFFFF_FFFF}; wr0 = 2'b10; q0.push_back('{d: 4'hF, c: 16'd3});
    tick();
    din0 = {32'h0, 32'h0000_0003}; wr0 = 2'b01; q0.push_back('{d: 4'h3, c: 16'd4});
    tick();
    wr0 = '0; din0 = '0;
    repeat (4) tick();
    check("u0_idle_data_zero", 32'(out0), 0);
    check("u0_cnt_total", 32'(cnt0), 32'd4);
    start0 = 1'b1;
    tick();
    check("u0_cnt_cleared_by_start", 32'(cnt0), 0);
    start0 = 1'b0;

    // signature mode: writes in IDLE are dropped
    din1 = 32'h0000_00FF; wr1 = 1'b1;
    tick();
    wr1 = 1'b0; din1 = '0;
    repeat (3) tick();
    check("u1_idle_write_ignored", 32'(cnt1), 0);

    run_two_beats();
    run_two_beats();

    // 20 beats of fold 1 into a 4-bit counter; signature cycles with period 8 -> F.
    // ap_done together with the start edge in IDLE must only start the run.
    q1.push_back('{d: 4'hF, c: 16'd15});
    start1 = 1'b1; done1 = 1'b1;
    tick();
    start1 = 1'b0; done1 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      din1 = 32'h0000_0001; wr1 = 1'b1; done1 = (i == 19);
      if (i == 19) done_cyc = cyc;
      tick();
    end
    wr1 = 1'b0; done1 = 1'b0; din1 = '0;
    repeat (6) tick();
    check("u1_sat_emit_latency", 32'(vld1_cyc - done_cyc), 32'd3);
    check("u1_cnt_saturated", 32'(cnt1), 32'd15);
    check("u1_overflow_set", 32'(ovf1), 32'd1);
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("u1_cnt_cleared", 32'(cnt1), 0);
    check("u1_overflow_cleared", 32'(ovf1), 0);

    // mid-run reset abandons the run
    din1 = 32'h0000_0001; wr1 = 1'b1;
    repeat (2) tick();
    wr1 = 1'b0;
    tick();
    check("u1_cnt_before_reset", 32'(cnt1), 32'd2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("u1_async_rst_cnt", 32'(cnt1), 0);
    check("u1_async_rst_valid", 32'(vld1), 0);
    check("u1_async_rst_data", 32'(out1), 0);
    tick();
    rst_n = 1'b1;
    done1 = 1'b1;
    tick();
    done1 = 1'b0;
    repeat (6) tick();
    check("u1_cnt_after_abandon", 32'(cnt1), 0);

    check("u0_queue_drained", 32'(q0.size()), 0);
    check("u1_queue_drained", 32'(q1.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/result_compactor.md
RESULT_COMPACTOR -- requirements
Module: result_compactor

Interface
REQ-001 Parameter NUM_CH, default 1, number of kernel output streams (1..8).
REQ-002 Parameter DATA_W, default 32, width of each stream word (integer multiple of OUT_W).
REQ-003 Parameter OUT_W, default 4, compacted output width (>=2).
REQ-004 Parameter MODE, default 0; 0 = per-beat fold, 1 = per-run signature.
REQ-005 Parameter CNT_W, default 16, beat counter width.
REQ-006 ap_clk  in  1  sole clock, all logic rising-edge.
REQ-007 ap_rst_n  in  1  asynchronous, active-low reset.
REQ-008 ap_start  in  1  kernel start level; a run begins on its rising edge.
REQ-009 ap_done  in  1  kernel done pulse.
REQ-010 in_data  in  NUM_CH*DATA_W  stream words; channel c at bits [c*DATA_W +: DATA_W].
REQ-011 in_write  in  NUM_CH  per-channel write strobe.
REQ-012 data_out  out  OUT_W  compacted result.
REQ-013 data_valid  out  1  data_out qualifier.
REQ-014 beat_cnt  out  CNT_W  accepted beats in the current or last run.
REQ-015 overflow  out  1  sticky beat_cnt saturation flag.

Function
REQ-016 Fold: a word is reduced to OUT_W bits by XOR of its DATA_W/OUT_W consecutive OUT_W-bit slices.
REQ-017 Stage 1 (registered): fold1 = XOR of folds of all channels with in_write set; valid1 = OR of gated strobes; fold1 = 0 when valid1 = 0.
REQ-018 Run start: rising edge of ap_start (current 1, previous registered sample 0) clears beat_cnt and overflow.
REQ-019 beat_cnt increments by 1 per cycle with valid1 = 1 (one beat regardless of channels set); saturates at 2^CNT_W-1; an increment attempted at saturation sets overflow.
REQ-020 MODE 0: strobes ungated; data_out = fold1, data_valid = valid1, registered, so latency 2 cycles from in_write to data_valid; data_out = 0 when data_valid = 0.
REQ-021 MODE 1 FSM states IDLE, RUN, DRAIN, EMIT; IDLE->RUN on run start; RUN->DRAIN on ap_done = 1; DRAIN->EMIT unconditionally; EMIT->IDLE unconditionally.
REQ-022 MODE 1: strobes gated by state == RUN; writes in IDLE, DRAIN, EMIT are ignored and not counted.
REQ-023 MODE 1: signature sig cleared on run start; in RUN and DRAIN, when valid1 = 1, sig <= (sig rotated left by 1) XOR fold1.
REQ-024 MODE 1: in EMIT, data_out = sig and data_valid = 1 for exactly one cycle; otherwise data_out = 0, data_valid = 0; data_valid rises 3 cycles after the cycle ap_done is sampled.
REQ-025 MODE 1: a write in the same cycle as ap_done is included in sig and beat_cnt.
REQ-026 MODE 1: ap_start rising edge outside IDLE is ignored; ap_done outside RUN is ignored.
REQ-027 MODE 1: ap_start rising and ap_done in the same IDLE cycle -> enter RUN only.

Reset
REQ-028 While ap_rst_n = 0: data_out = 0, data_valid = 0, beat_cnt = 0, overflow = 0, sig = 0, stage 1 = 0, previous ap_start sample = 0, FSM = IDLE, effective immediately.
REQ-029 Reset mid-run abandons the run; no EMIT occurs for it.
REQ-030 First rising edge after release performs normal operation.

Verification
REQ-031 MODE 0, NUM_CH 1: in_data 0x12345678, in_write for one cycle -> 2 cycles later data_out 0x8, data_valid 1 for one cycle, beat_cnt 1.
REQ-032 MODE 0, NUM_CH 2: ch0 0x0000000F, ch1 0x000000F0, both strobes in the same cycle -> data_out 0x0, data_valid 1, beat_cnt +1.
REQ-033 MODE 1: run start, beats 0x00000001 then 0x00000004, ap_done with the second beat -> single EMIT, data_out 0x6, beat_cnt 2, data_valid 3 cycles after ap_done.
REQ-034 MODE 1: beat in the cycle after ap_done -> excluded; a second run gives an identical signature for identical stimulus.
REQ-035 CNT_W 4: 20 beats in one run -> beat_cnt 15, overflow 1; next ap_start rising edge -> both 0.
REQ-036 MODE 1: ap_rst_n low for one cycle in RUN -> all outputs 0 asynchronously; a later ap_done -> no data_valid.
